// File: rtl/sum_zero_seq_pkg.sv
// Shared types and configuration helpers for the chunked add-and-zero-test sequencer.
package sum_zero_seq_pkg;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_CHUNK = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic bit chunk_ok(input int unsigned width, input int unsigned chunk);
    return (chunk != 0) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/SumZeroDet.sv
// Detects (a + b + c) == 0 mod 2^width straight from the operands, without waiting on the carry chain.
module SumZeroDet #(
  parameter int unsigned width = 16
) (
  input  logic [width-1:0] i_a,
  input  logic [width-1:0] i_b,
  input  logic             i_c,
  output logic             o_z
);

  logic [width-1:0] w_t;
  logic [width-1:0] w_kin;

  assign w_t = i_a ^ i_b;

  // If every lower sum bit is zero, the carry into bit i+1 is exactly a[i]|b[i].
  if (width == 1) begin : g_one
    assign w_kin = i_c;
  end else begin : g_multi
    assign w_kin = {i_a[width-2:0] | i_b[width-2:0], i_c};
  end

  assign o_z = &(~(w_t ^ w_kin));

endmodule

// File: rtl/sum_zero_seq_ctrl.sv
// Sequences a WIDTH-bit add with zero test over CHUNK-bit slices, carry chained between cycles.
//  state | meaning
//  IDLE  | ready for operands
//  RUN   | processing chunk r_k, one per cycle
//  DONE  | result valid, held until consumer accepts
module sum_zero_seq_ctrl
  import sum_zero_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o,
  output logic             zero_o,
  output logic             busy_o
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("sum_zero_seq_ctrl: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e r_state;
  state_e w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_zacc;
  logic [CW-1:0]    r_k;

  logic [CHUNK-1:0] w_ak;
  logic [CHUNK-1:0] w_bk;
  logic [CHUNK:0]   w_s;
  logic             w_zk;
  logic             w_accept;

  assign w_ak     = r_a[r_k*CHUNK +: CHUNK];
  assign w_bk     = r_b[r_k*CHUNK +: CHUNK];
  assign w_s      = {1'b0, w_ak} + {1'b0, w_bk} + {{CHUNK{1'b0}}, r_carry};
  assign w_accept = (r_state == IDLE) && in_valid_i && !flush_i;

  SumZeroDet #(.width(CHUNK)) u_zdet (
    .i_a (w_ak),
    .i_b (w_bk),
    .i_c (r_carry),
    .o_z (w_zk)
  );

  always_comb begin
    w_next = r_state;
    if (flush_i) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid_i) w_next = RUN;
        RUN:     if (r_k == LAST) w_next = DONE;
        DONE:    if (out_ready_i) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Flush leaves the datapath untouched; only the FSM is pulled back to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_zacc  <= 1'b0;
      r_k     <= '0;
    end else if (w_accept) begin
      r_a     <= a_i;
      r_b     <= b_i;
      r_carry <= ci_i;
      r_zacc  <= 1'b1;
      r_k     <= '0;
    end else if ((r_state == RUN) && !flush_i) begin
      r_sum[r_k*CHUNK +: CHUNK] <= w_s[CHUNK-1:0];
      r_carry <= w_s[CHUNK];
      r_zacc  <= r_zacc & w_zk;
      if (r_k != LAST) r_k <= r_k + 1'b1;
    end
  end

  assign in_ready_o  = (r_state == IDLE);
  assign out_valid_o = (r_state == DONE);
  assign busy_o      = (r_state != IDLE);
  assign sum_o       = r_sum;
  assign co_o        = r_carry;
  assign zero_o      = r_zacc;

endmodule

// File: tb/tb_sum_zero_seq_ctrl.sv
// Random and directed checks of sum_zero_seq_ctrl against a cycle-level behavioural model.
module tb_sum_zero_seq_ctrl;

  localparam int W  = 64;
  localparam int C  = 16;
  localparam int NC = W / C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         ci = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, co, zero, busy;
  logic [W-1:0] sum;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sum_zero_seq_ctrl #(.WIDTH(W), .CHUNK(C)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .ci_i        (ci),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .co_o        (co),
    .zero_o      (zero),
    .busy_o      (busy)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  function automatic logic [W:0] add3(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Behavioural model: an op is pending from acceptance until its handshake; valid after NC cycles.
  logic         m_busy, m_valid, m_clean, m_co, m_zero;
  logic [W-1:0] m_sum;
  int           m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_clean <= 1'b1;
      m_sum <= '0; m_co <= 1'b0; m_zero <= 1'b0; m_cnt <= 0;
    end else if (flush) begin
      m_busy <= 1'b0; m_valid <= 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy  <= 1'b1;
        m_clean <= 1'b0;
        m_cnt   <= 0;
        {m_co, m_sum} <= add3(a, b, ci);
        m_zero  <= (add3(a, b, ci) & {1'b0, {W{1'b1}}}) == '0;
      end
    end else if (!m_valid) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == NC) m_valid <= 1'b1;
    end else if (out_ready) begin
      m_busy <= 1'b0; m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_in_ready", in_ready, !m_busy);
      chk("cyc_busy", busy, m_busy);
      chk("cyc_out_valid", out_valid, m_valid);
      if (m_valid || m_clean) begin
        chk("cyc_sum", sum, m_sum);
        chk("cyc_co", co, m_co);
        chk("cyc_zero", zero, m_zero);
      end
    end
  end

  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ici,
                    input int hold, output logic [W-1:0] s, output logic c, output logic z,
                    output int lat);
    @(posedge clk); #1;
    in_valid = 1'b1; a = ia; b = ib; ci = ici; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("op_valid_rose", out_valid, 1'b1);
    chk("op_latency", lat, NC);
    s = sum; c = co; z = zero;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_sum", sum, s);
      chk("hold_co", co, c);
      chk("hold_zero", zero, z);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 1'b0);
    chk("post_hs_ready", in_ready, 1'b1);
  endtask

  initial begin : main
    logic [W-1:0] s, ra, rb, ones;
    logic [W:0]   e;
    logic         c, z, rci;
    int           lat, hold;
    ones = '1;

    #22 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, '0);
    chk("rst_co", co, 1'b0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_busy", busy, 1'b0);

    op('0, '0, 1'b0, 0, s, c, z, lat);
    chk("t1_sum", s, '0); chk("t1_co", c, 1'b1 ^ 1'b1); chk("t1_zero", z, 1'b1);

    op(ones, '0, 1'b1, 0, s, c, z, lat);
    chk("t2_sum", s, '0); chk("t2_co", c, 1'b1); chk("t2_zero", z, 1'b1);

    op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 0, s, c, z, lat);
    chk("t3_sum", s, 64'h1_0000); chk("t3_co", c, 1'b0); chk("t3_zero", z, 1'b0);

    op(ones, '0, 1'b1, 5, s, c, z, lat);
    chk("t4_sum", s, '0); chk("t4_co", c, 1'b1); chk("t4_zero", z, 1'b1);

    // flush in the second RUN cycle
    @(posedge clk); #1;
    in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom}; ci = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_busy", busy, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("flush_no_valid", out_valid, 1'b0);
    end

    // in_valid together with flush in IDLE is not accepted
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", busy, 1'b0);

    op(64'd5, -64'd5, 1'b0, 0, s, c, z, lat);
    chk("t5_sum", s, '0); chk("t5_co", c, 1'b1); chk("t5_zero", z, 1'b1);

    // asynchronous reset while DONE
    @(posedge clk); #1;
    in_valid = 1'b1; a = 64'h1234_5678_9ABC_DEF0; b = 64'h1111_1111_1111_1111; ci = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t6_valid_rose", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_sum", sum, '0);
    chk("t6_rst_co", co, 1'b0);
    chk("t6_rst_zero", zero, 1'b0);
    chk("t6_rst_ready", in_ready, 1'b1);
    chk("t6_rst_busy", busy, 1'b0);
    #10 rst_n = 1'b1;

    for (int n = 0; n < 40; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rci = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: ;
        1: begin rb = -ra; rci = 1'b0; end
        2: begin ra = ones; rb = '0; end
        default: rb = {32'd0, 16'd0, 16'($urandom)};
      endcase
      hold = $urandom_range(0, 3);
      e = add3(ra, rb, rci);
      op(ra, rb, rci, hold, s, c, z, lat);
      chk("rnd_sum", s, e[W-1:0]);
      chk("rnd_co", c, e[W]);
      chk("rnd_zero", z, e[W-1:0] == '0);
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
